// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the hazard-scoreboard slot type.
package pipe_pkg;

  localparam logic [31:0] NOP_IR   = 32'h6800_0000;
  localparam int          REG_W    = 4;
  localparam int          NUM_REGS = 16;
  localparam int          RA_REG   = 15;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             is_load;
  } sb_slot_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot destination scoreboard (EX/MA/RW) and RAW match logic for the
// instruction currently sitting in OF.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int FWD_EN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             of_valid,
  input  logic [REG_W-1:0] of_src1,
  input  logic             of_src1_used,
  input  logic [REG_W-1:0] of_src2,
  input  logic             of_src2_used,
  input  logic [REG_W-1:0] of_dst,
  input  logic             of_dst_wr,
  input  logic             of_is_load,
  input  logic             bubble,
  output logic             raw
);

  sb_slot_t ex_q, ma_q, rw_q;
  sb_slot_t ex_d;
  logic     m_ex, m_ma, m_rw;
  logic     unused_load_bits;

  function automatic logic src_hit(input sb_slot_t s,
                                   input logic [REG_W-1:0] s1, input logic s1u,
                                   input logic [REG_W-1:0] s2, input logic s2u);
    return s.valid & ((s1u & (s.dst == s1)) | (s2u & (s.dst == s2)));
  endfunction

  // A bubbled instruction never reaches EX, so it must not occupy a slot.
  always_comb begin
    ex_d         = '0;
    ex_d.valid   = of_valid & of_dst_wr & ~bubble;
    ex_d.dst     = of_dst;
    ex_d.is_load = of_is_load;
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      ex_q.valid <= 1'b0;
      ma_q.valid <= 1'b0;
      rw_q.valid <= 1'b0;
    end else begin
      ex_q <= ex_d;
      ma_q <= ex_q;
      rw_q <= ma_q;
    end
  end

  always_comb begin
    m_ex = src_hit(ex_q, of_src1, of_src1_used, of_src2, of_src2_used);
    m_ma = src_hit(ma_q, of_src1, of_src1_used, of_src2, of_src2_used);
    m_rw = src_hit(rw_q, of_src1, of_src1_used, of_src2, of_src2_used);
    // With forwarding only a load result is still unavailable one stage later.
    if (FWD_EN != 0) raw = of_valid & m_ex & ex_q.is_load;
    else             raw = of_valid & (m_ex | m_ma | m_rw);
  end

  assign unused_load_bits = ma_q.is_load ^ rw_q.is_load;

endmodule

// File: rtl/of_ex_interlock_ctrl.sv
// OF->EX interlock controller: RAW stall, taken-branch flush window, PC and
// IF/OF hold enables, and stall/flush performance counters.
module of_ex_interlock_ctrl
  import pipe_pkg::*;
#(
  parameter int FWD_EN = 0,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     of_valid,
  input  logic [pipe_pkg::REG_W-1:0] of_src1,
  input  logic                     of_src1_used,
  input  logic [pipe_pkg::REG_W-1:0] of_src2,
  input  logic                     of_src2_used,
  input  logic [pipe_pkg::REG_W-1:0] of_dst,
  input  logic                     of_dst_wr,
  input  logic                     of_is_load,
  input  logic                     ex_branch_taken,
  output logic                     isDataInterLock,
  output logic                     isBranchInterLock,
  output logic                     pc_stall,
  output logic                     if_of_stall,
  output logic [CNT_W-1:0]         stall_count,
  output logic [CNT_W-1:0]         flush_count
);

  if ((1 << pipe_pkg::REG_W) != NUM_REGS) begin : g_regw_check
    $error("register index width does not cover the register file");
  end

  logic             raw;
  logic             bubble;
  logic             flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  hazard_scoreboard #(
    .FWD_EN(FWD_EN)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .of_valid     (of_valid),
    .of_src1      (of_src1),
    .of_src1_used (of_src1_used),
    .of_src2      (of_src2),
    .of_src2_used (of_src2_used),
    .of_dst       (of_dst),
    .of_dst_wr    (of_dst_wr),
    .of_is_load   (of_is_load),
    .bubble       (bubble),
    .raw          (raw)
  );

  // Branch flush outranks the data stall: a wrong-path instruction is dropped.
  always_comb begin
    isBranchInterLock = ~rst & (ex_branch_taken | flush_pend_q);
    isDataInterLock   = ~rst & raw & ~isBranchInterLock;
    pc_stall          = isDataInterLock;
    if_of_stall       = isDataInterLock;
    bubble            = isDataInterLock | isBranchInterLock;
  end

  always_comb begin
    flush_pend_d = ex_branch_taken;
    stall_cnt_d  = stall_cnt_q + CNT_W'(isDataInterLock);
    flush_cnt_d  = flush_cnt_q + CNT_W'(isBranchInterLock);
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      flush_pend_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      flush_pend_q <= flush_pend_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign stall_count = rst ? '0 : stall_cnt_q;
  assign flush_count = rst ? '0 : flush_cnt_q;

endmodule
